// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and response type for the register-file slave.
package axi_lite_pkg;

   localparam int ADDR_LSB = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

endpackage

// File: rtl/axi_lite_aw_w_join.sv
// Joins the independent AW and W channels into a single write-commit strobe.
// Each channel is captured into its own hold register; the commit fires on
// the edge where both an address and data are available, held or live.
module axi_lite_aw_w_join #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                S_AXI_ACLK,
   input  logic                S_AXI_ARESETN,
   input  logic                rst_done,
   input  logic                bvalid,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                commit,
   output logic [ADDR_W-1:0]   commit_addr,
   output logic [DATA_W-1:0]   commit_data,
   output logic [DATA_W/8-1:0] commit_strb
);

   logic                aw_hold, w_hold;
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   w_data_q;
   logic [DATA_W/8-1:0] w_strb_q;
   logic                aw_hs, w_hs;

   // A pending response blocks new traffic so only one write is ever in flight.
   assign awready = ~aw_hold & ~bvalid & rst_done;
   assign wready  = ~w_hold  & ~bvalid & rst_done;
   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid  & wready;

   assign commit      = (aw_hold | aw_hs) & (w_hold | w_hs);
   assign commit_addr = aw_hold ? aw_addr_q : awaddr;
   assign commit_data = w_hold  ? w_data_q  : wdata;
   assign commit_strb = w_hold  ? w_strb_q  : wstrb;

   // Capture each channel on its handshake; release both holds on commit.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         aw_hold   <= 1'b0;
         w_hold    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else if (commit) begin
         aw_hold <= 1'b0;
         w_hold  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_hold   <= 1'b1;
            aw_addr_q <= awaddr;
         end
         if (w_hs) begin
            w_hold   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
      end
   end

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave: NUM_RW byte-writable control registers followed by NUM_RO
// status words. Anything beyond the bank answers SLVERR with no side effects.
module axi_lite_slave_regfile
   import axi_lite_pkg::*;
#(
   parameter int                          S_AXI_DATA_WIDTH = 32,
   parameter int                          S_AXI_ADDR_WIDTH = 32,
   parameter int                          NUM_RW           = 8,
   parameter int                          NUM_RO           = 4,
   parameter logic [S_AXI_DATA_WIDTH-1:0] RW_RESET         = '0
) (
   input  logic                               S_AXI_ACLK,
   input  logic                               S_AXI_ARESETN,
   input  logic                               S_AXI_AWVALID,
   output logic                               S_AXI_AWREADY,
   input  logic [S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                         S_AXI_AWPROT,
   input  logic                               S_AXI_WVALID,
   output logic                               S_AXI_WREADY,
   input  logic [S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   output logic                               S_AXI_BVALID,
   input  logic                               S_AXI_BREADY,
   output logic [1:0]                         S_AXI_BRESP,
   input  logic                               S_AXI_ARVALID,
   output logic                               S_AXI_ARREADY,
   input  logic [S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                         S_AXI_ARPROT,
   output logic                               S_AXI_RVALID,
   input  logic                               S_AXI_RREADY,
   output logic [S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                         S_AXI_RRESP,
   output logic [S_AXI_DATA_WIDTH*NUM_RW-1:0] regs_out,
   output logic [NUM_RW-1:0]                  wr_pulse,
   input  logic [S_AXI_DATA_WIDTH*NUM_RO-1:0] ro_in
);

   localparam int IDX_W  = S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int STRB_W = S_AXI_DATA_WIDTH / 8;

   logic                                     rst_done;
   logic [NUM_RW-1:0][S_AXI_DATA_WIDTH-1:0]  regs;
   logic                                     commit;
   logic [S_AXI_ADDR_WIDTH-1:0]              commit_addr;
   logic [S_AXI_DATA_WIDTH-1:0]              commit_data;
   logic [STRB_W-1:0]                        commit_strb;
   logic [IDX_W-1:0]                         wr_idx, rd_idx;
   logic                                     wr_ok;
   logic                                     bvalid_q, rvalid_q;
   resp_t                                    bresp_q, rresp_q, rd_resp;
   logic [S_AXI_DATA_WIDTH-1:0]              rdata_q, rd_data;
   logic                                     ar_hs;
   logic                                     unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        commit_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   // Hold off all READYs until the first edge after reset release.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) rst_done <= 1'b0;
      else                rst_done <= 1'b1;
   end

   axi_lite_aw_w_join #(
      .ADDR_W (S_AXI_ADDR_WIDTH),
      .DATA_W (S_AXI_DATA_WIDTH)
   ) u_join (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .rst_done      (rst_done),
      .bvalid        (bvalid_q),
      .awvalid       (S_AXI_AWVALID),
      .awready       (S_AXI_AWREADY),
      .awaddr        (S_AXI_AWADDR),
      .wvalid        (S_AXI_WVALID),
      .wready        (S_AXI_WREADY),
      .wdata         (S_AXI_WDATA),
      .wstrb         (S_AXI_WSTRB),
      .commit        (commit),
      .commit_addr   (commit_addr),
      .commit_data   (commit_data),
      .commit_strb   (commit_strb)
   );

   assign wr_idx = commit_addr[S_AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign wr_ok  = wr_idx < IDX_W'(NUM_RW);

   // Byte-merge committed data into the addressed RW register and strobe it.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         regs     <= {NUM_RW{RW_RESET}};
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         for (int i = 0; i < NUM_RW; i++) begin
            if (commit && wr_idx == IDX_W'(i)) begin
               wr_pulse[i] <= 1'b1;
               for (int b = 0; b < STRB_W; b++)
                  if (commit_strb[b]) regs[i][8*b +: 8] <= commit_data[8*b +: 8];
            end
         end
      end
   end

   // Write response: raised by the commit, held until the master takes it.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else if (commit) begin
         bvalid_q <= 1'b1;
         bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_q <= 1'b0;
      end
   end

   assign rd_idx = S_AXI_ARADDR[S_AXI_ADDR_WIDTH-1:ADDR_LSB];

   // Read decode: RW bank, then status words, else zero with SLVERR.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_data = regs[i];
            rd_resp = RESP_OKAY;
         end
      end
      for (int j = 0; j < NUM_RO; j++) begin
         if (rd_idx == IDX_W'(NUM_RW + j)) begin
            rd_data = ro_in[S_AXI_DATA_WIDTH*j +: S_AXI_DATA_WIDTH];
            rd_resp = RESP_OKAY;
         end
      end
   end

   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   // Read data register: loads on AR handshake (pre-write value on a same-edge
   // commit), held stable until RREADY, then cleared.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_data;
         rresp_q  <= rd_resp;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end
   end

   assign S_AXI_ARREADY = ~rvalid_q & rst_done;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign regs_out      = regs;

endmodule

// File: doc/axi_lite_slave_regfile.md
# axi_lite_slave_regfile

AXI4-Lite slave exposing a bank of 32-bit software-visible control registers plus read-only status registers to the fabric. It is the responder-side counterpart of the testbench CPU master: accelerator blocks receive configuration through it, and the bench's Xil_Out32/Xil_In32 traffic terminates on it. Writes and reads are served independently, one outstanding transaction per direction.

## Interface
- S_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- S_AXI_ADDR_WIDTH, 32, address width.
- NUM_RW, 8, number of read/write registers (word index 0..NUM_RW-1).
- NUM_RO, 4, number of read-only registers (word index NUM_RW..NUM_RW+NUM_RO-1).
- RW_RESET, 0, reset value of every RW register.

- S_AXI_ACLK  in  1  clock; one clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake; S_AXI_AWADDR in S_AXI_ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored).
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake; S_AXI_WDATA in 32; S_AXI_WSTRB in 4 byte enables.
- S_AXI_BVALID out 1, S_AXI_BREADY in 1, S_AXI_BRESP out 2  write response.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake; S_AXI_ARADDR in S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored).
- S_AXI_RVALID out 1, S_AXI_RREADY in 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2  read data.
- regs_out  out  32*NUM_RW  RW register contents, register i at bits [32*i+:32].
- wr_pulse  out  NUM_RW  one-cycle strobe, bit i on the edge register i is written.
- ro_in  in  32*NUM_RO  status inputs, sampled at read-address handshake.

## Operation
- Decode: word index = ADDR[S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] ignored.
- Write path: AW and W accepted independently in any order; each captured into a hold register with a hold flag.
- AWREADY = ~aw_hold & ~BVALID & rst_done; WREADY = ~w_hold & ~BVALID & rst_done.
- Commit on the edge where both address and data are available (held or handshaking that edge): bytes with WSTRB=1 updated; BVALID set; both hold flags cleared.
- BRESP: OKAY (2'b00) for RW index; SLVERR (2'b10) for RO index or index >= NUM_RW+NUM_RO, no state change, no wr_pulse.
- wr_pulse[i] fires on every OKAY commit to i, including WSTRB=4'b0000.
- BVALID held until BREADY; cleared on the BVALID&BREADY edge.
- Read path: ARREADY = ~RVALID & rst_done. On handshake, RDATA/RRESP registered, RVALID set.
- RDATA: RW register, ro_in word, or 0 with RRESP=SLVERR when out of range.
- RVALID, RDATA, RRESP stable until RREADY; cleared on RVALID&RREADY.
- rst_done: flag cleared by reset, set on the first clock edge after deassertion.

## Timing
- Reset values: all READY 0, BVALID 0, RVALID 0, BRESP/RRESP 0, RDATA 0, regs_out all RW_RESET, wr_pulse 0.
- Write latency: BVALID and regs_out update visible the cycle after the later of AW/W handshake.
- Read latency: RVALID the cycle after AR handshake; back-to-back reads every 2 cycles with RREADY tied high.
- Simultaneous read and write commit to the same register on one edge: read returns the pre-write value.
- Duplicate AW while aw_hold set: AWREADY low, stalls; same for W.
- Reset mid-transaction: holds, BVALID, RVALID dropped immediately; pending write is discarded and does not commit.

## Structure
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ADDR_LSB=2, and a resp_t typedef.
- One natural sub-module: axi_lite_aw_w_join (hold registers, flags, READY generation, commit strobe). Register bank and read mux stay in the top.

## Test plan
- Write 0x12345678 to 0x04 via Xil_Out32 -> BRESP OKAY, regs_out[63:32]=0x12345678, wr_pulse[1] one cycle, Xil_In32(0x04) returns 0x12345678.
- W two cycles before AW, WSTRB=4'b0101, data 0xAABBCCDD onto 0xFFFFFFFF at index 0 -> register 0xFFBBFFDD, BVALID exactly one cycle after the AW handshake.
- ro_in word 0 = 0xCAFEF00D, read 0x20 (NUM_RW=8) -> RDATA 0xCAFEF00D OKAY; write 0x20 -> SLVERR, no wr_pulse, subsequent read still reads ro_in.
- Read 0x40 (index 16) -> RDATA 0, RRESP SLVERR; write 0x40 -> SLVERR, regs_out unchanged.
- BREADY held low 5 cycles -> BVALID stays 1, AWREADY/WREADY 0 throughout; next write accepted after B handshake.
- Assert reset after AW handshake before W -> all outputs at reset values; after release, read 0x00 returns RW_RESET.
